// File: rtl/mem_arb_pkg.sv
`default_nettype none
// mem_arb_pkg: state encoding, requester ids and latency-counter width for mem_port_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;
  localparam int   CNT_W  = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// mem_arb_pick: combinational winner select between fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise data has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_winner,
`endif
  output logic winner,
  output logic valid
);

  always_comb begin
    valid  = if_req | d_req;
    winner = d_req ? REQ_D : REQ_IF;
`ifdef MEM_ARB_RR_EN
    // On contention, the requester that did not win last time goes next.
    if (if_req && d_req) begin
      winner = (last_winner == REQ_D) ? REQ_IF : REQ_D;
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: shares one RAM port between fetch and data paths (issue/wait/response).
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data-over-fetch priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          ram_en_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic          busy_o
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be within 1..15");
  end

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cmd_id;
  logic [DW-1:0]    rdata;
  logic             pick_winner;
  logic             pick_valid;

`ifdef MEM_ARB_RR_EN
  logic             last_winner;
`endif

  mem_arb_pick u_pick (
    .if_req      (if_req_i),
    .d_req       (d_req_i),
`ifdef MEM_ARB_RR_EN
    .last_winner (last_winner),
`endif
    .winner      (pick_winner),
    .valid       (pick_valid)
  );

  assign busy_o     = (state != IDLE);
  assign if_rdata_o = rdata;
  assign d_rdata_o  = rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_id      <= REQ_IF;
      rdata       <= '0;
      ram_en_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      if_gnt_o    <= 1'b0;
      d_gnt_o     <= 1'b0;
      if_rvalid_o <= 1'b0;
      d_rvalid_o  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_winner <= REQ_IF;
`endif
    end else begin
      // Strobes are single-cycle; only the transitions below raise them.
      ram_en_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      if_gnt_o    <= 1'b0;
      d_gnt_o     <= 1'b0;
      if_rvalid_o <= 1'b0;
      d_rvalid_o  <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (pick_valid) begin
            state      <= ISSUE;
            cmd_id     <= pick_winner;
            ram_en_o   <= 1'b1;
            ram_we_o   <= (pick_winner == REQ_D) && d_we_i;
            ram_addr_o <= (pick_winner == REQ_D) ? d_addr_i : if_addr_i;
            if (pick_winner == REQ_D) begin
              ram_wdata_o <= d_wdata_i;
            end
            if_gnt_o   <= (pick_winner == REQ_IF);
            d_gnt_o    <= (pick_winner == REQ_D);
`ifdef MEM_ARB_RR_EN
            last_winner <= pick_winner;
`endif
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (ram_we_o) begin
            state <= IDLE;
          end else begin
            state <= WAIT;
            cnt   <= LAT_LOAD;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rdata       <= ram_rdata_i;
            state       <= RESP;
            if_rvalid_o <= (cmd_id == REQ_IF);
            d_rvalid_o  <= (cmd_id == REQ_D);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Testbench for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int NC  = 700;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_gnt_o, if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i = 1'b0;
  logic          d_we_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic [DW-1:0] d_wdata_i = '0;
  logic          d_gnt_o, d_rvalid_o;
  logic [DW-1:0] d_rdata_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o;
  logic [DW-1:0] ram_rdata_i = '0;
  logic          busy_o;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_gnt_o     (d_gnt_o),
    .d_rvalid_o  (d_rvalid_o),
    .d_rdata_o   (d_rdata_o),
    .ram_en_o    (ram_en_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int avail = 0;

  // Expected per-cycle activity, filled in when a request is arbitrated.
  bit          e_en[NC], e_we[NC], e_ifg[NC], e_dg[NC], e_ifv[NC], e_dv[NC], e_busy[NC], e_cap_v[NC];
  logic [31:0] e_addr[NC], e_wdata[NC], e_cap_d[NC];
  logic [31:0] cur_addr, cur_rd;

  // Environment RAM: read data is presented only in the cycle it is due.
  bit          rd_v[NC];
  logic [31:0] rd_d[NC];
  logic [31:0] ram_mem[logic [31:0]];
  logic [31:0] model_mem[logic [31:0]];

  // Requester state: index 0 = fetch, 1 = data.
  bit          act[2], gntd[2], r_we[2];
  int          gcyc[2];
  logic [31:0] r_addr[2], r_wd[2];
`ifdef MEM_ARB_RR_EN
  int          last_w;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".ram_en"}, ram_en_o, 0);
    chk({tag, ".ram_we"}, ram_we_o, 0);
    chk({tag, ".ram_addr"}, ram_addr_o, 0);
    chk({tag, ".ram_wdata"}, ram_wdata_o, 0);
    chk({tag, ".if_gnt"}, if_gnt_o, 0);
    chk({tag, ".d_gnt"}, d_gnt_o, 0);
    chk({tag, ".if_rvalid"}, if_rvalid_o, 0);
    chk({tag, ".d_rvalid"}, d_rvalid_o, 0);
    chk({tag, ".if_rdata"}, if_rdata_o, 0);
    chk({tag, ".d_rdata"}, d_rdata_o, 0);
    chk({tag, ".busy"}, busy_o, 0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NC; i++) begin
      e_en[i] = 0; e_we[i] = 0; e_ifg[i] = 0; e_dg[i] = 0; e_ifv[i] = 0; e_dv[i] = 0;
      e_busy[i] = 0; e_cap_v[i] = 0; e_addr[i] = 0; e_wdata[i] = 0; e_cap_d[i] = 0;
      rd_v[i] = 0; rd_d[i] = 0;
    end
    cyc = 0; avail = 0; cur_addr = 0; cur_rd = 0;
    for (int k = 0; k < 2; k++) begin
      act[k] = 0; gntd[k] = 0; r_we[k] = 0; gcyc[k] = 0; r_addr[k] = 0; r_wd[k] = 0;
    end
`ifdef MEM_ARB_RR_EN
    last_w = 0;
`endif
    if_req_i = 0; d_req_i = 0; d_we_i = 0;
  endtask

  task automatic step(input bit quiet);
    int w;
    bit pi, pd;
    logic [31:0] a;
    @(negedge clk);
    if (e_en[cyc]) cur_addr = e_addr[cyc];
    if (e_cap_v[cyc]) cur_rd = e_cap_d[cyc];
    chk("ram_en", ram_en_o, e_en[cyc]);
    chk("ram_we", ram_we_o, e_we[cyc]);
    chk("ram_addr", ram_addr_o, cur_addr);
    if (e_en[cyc] && e_we[cyc]) chk("ram_wdata", ram_wdata_o, e_wdata[cyc]);
    chk("if_gnt", if_gnt_o, e_ifg[cyc]);
    chk("d_gnt", d_gnt_o, e_dg[cyc]);
    chk("if_rvalid", if_rvalid_o, e_ifv[cyc]);
    chk("d_rvalid", d_rvalid_o, e_dv[cyc]);
    chk("busy", busy_o, e_busy[cyc]);
    chk("if_rdata", if_rdata_o, cur_rd);
    chk("d_rdata", d_rdata_o, cur_rd);

    // RAM reacts to what the DUT actually drives.
    if (ram_en_o === 1'b1 && ram_we_o === 1'b1) ram_mem[ram_addr_o] = ram_wdata_o;
    if (ram_en_o === 1'b1 && ram_we_o === 1'b0) begin
      rd_v[cyc] = 1;
      rd_d[cyc] = ram_mem.exists(ram_addr_o) ? ram_mem[ram_addr_o] : dflt(ram_addr_o);
    end
    ram_rdata_i = (cyc >= LAT && rd_v[cyc-LAT]) ? rd_d[cyc-LAT] : $urandom;

    for (int k = 0; k < 2; k++) begin
      if (act[k] && gntd[k] && cyc > gcyc[k]) begin
        act[k] = 0; gntd[k] = 0;
      end
      if (act[k] && !gntd[k] && !quiet && $urandom_range(0, 15) == 0) act[k] = 0;
      if (!act[k] && !quiet && $urandom_range(0, 2) == 0) begin
        act[k]    = 1;
        r_addr[k] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        r_we[k]   = (k == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        r_wd[k]   = $urandom;
      end
    end

    // Transaction-level timing: a write occupies the port for 2 cycles,
    // a read for LAT+2 cycles before the next decision.
    if (cyc >= avail) begin
      pi = act[0] && !gntd[0];
      pd = act[1] && !gntd[1];
      if (pi || pd) begin
        if (pi && pd) begin
`ifdef MEM_ARB_RR_EN
          w = (last_w == 1) ? 0 : 1;
`else
          w = 1;
`endif
        end else begin
          w = pd ? 1 : 0;
        end
`ifdef MEM_ARB_RR_EN
        last_w = w;
`endif
        gntd[w] = 1; gcyc[w] = cyc + 1;
        e_en[cyc+1] = 1; e_we[cyc+1] = r_we[w]; e_addr[cyc+1] = r_addr[w];
        e_wdata[cyc+1] = r_wd[w]; e_busy[cyc+1] = 1;
        if (w == 1) e_dg[cyc+1] = 1; else e_ifg[cyc+1] = 1;
        a = r_addr[w];
        if (r_we[w]) begin
          model_mem[a] = r_wd[w];
          avail = cyc + 2;
        end else begin
          for (int j = cyc + 1; j <= cyc + LAT + 2; j++) e_busy[j] = 1;
          if (w == 1) e_dv[cyc+LAT+2] = 1; else e_ifv[cyc+LAT+2] = 1;
          e_cap_v[cyc+LAT+2] = 1;
          e_cap_d[cyc+LAT+2] = model_mem.exists(a) ? model_mem[a] : dflt(a);
          avail = cyc + LAT + 2;
        end
      end
    end

    if_req_i  = act[0];
    if_addr_i = act[0] ? r_addr[0] : $urandom;
    d_req_i   = act[1];
    d_we_i    = act[1] ? r_we[1] : 1'($urandom_range(0, 1));
    d_addr_i  = act[1] ? r_addr[1] : $urandom;
    d_wdata_i = act[1] ? r_wd[1] : $urandom;
    cyc++;
  endtask

  initial begin
    int t_issue;
    clear_model();
    @(negedge clk); chk_zero("rst_init0");
    @(negedge clk); chk_zero("rst_init1");
    reset = 0;

    for (int n = 0; n < 450; n++) step(0);
    for (int n = 0; n < 20; n++) step(1);

    // Fetch read of a known word.
    ram_mem[32'h100] = 32'hDEAD_BEEF; model_mem[32'h100] = 32'hDEAD_BEEF;
    act[0] = 1; r_addr[0] = 32'h100; r_we[0] = 0;
    for (int n = 0; n < LAT + 5; n++) step(1);

    // Data write.
    act[1] = 1; r_addr[1] = 32'h200; r_we[1] = 1; r_wd[1] = 32'h1234_5678;
    for (int n = 0; n < 4; n++) step(1);

    // Simultaneous reads.
    act[0] = 1; r_addr[0] = 32'h100; r_we[0] = 0;
    act[1] = 1; r_addr[1] = 32'h200; r_we[1] = 0;
    for (int n = 0; n < 2 * (LAT + 3) + 3; n++) step(1);

    // Fetch read interrupted by reset while waiting on the RAM.
    act[0] = 1; r_addr[0] = 32'h104; r_we[0] = 0;
    step(1);
    t_issue = gcyc[0];
    chk("rst_wait.granted", {31'd0, gntd[0]}, 1);
    while (cyc <= t_issue + 2) step(1);
    #1 reset = 1;
    #1 chk_zero("rst_async");
    @(negedge clk); chk_zero("rst_hold");
    reset = 0;
    clear_model();
    for (int n = 0; n < LAT + 8; n++) step(1);

    for (int n = 0; n < 400; n++) step(0);
    for (int n = 0; n < 20; n++) step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
